// File: rtl/message_scroller.sv
// message_scroller
//   Scrolls a DIGITS-character window across a writable MSG_LEN-character
//   message. The window start (index) advances on a scroll-period tick when
//   auto_en is high, and on every rising edge of the step input.
//
// Ports
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high; restores index, counter, step
//                 history, the default message and the default window
//   auto_en  in   1 = advance on period tick, 0 = advance on step only
//   dir      in   0 = index increments, 1 = index decrements
//   step     in   level input; each sampled 0->1 transition requests one advance
//   wr_en    in   message write strobe
//   wr_addr  in   message write address (values >= MSG_LEN ignored)
//   wr_data  in   message write data
//   chars    out  registered window, slice k at [(DIGITS-k)*CHAR_W-1 -: CHAR_W]
//   index    out  registered window start position
//   tick     out  pulse in the cycle the period counter equals TICK_MAX
module message_scroller #(
  parameter int MSG_LEN  = 16,
  parameter int DIGITS   = 4,
  parameter int CHAR_W   = 4,
  parameter int TICK_MAX = 3125000,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
  localparam int CW = $clog2(TICK_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       auto_en,
  input  logic                       dir,
  input  logic                       step,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [CHAR_W-1:0]          wr_data,
  output logic [DIGITS*CHAR_W-1:0]   chars,
  output logic [AW-1:0]              index,
  output logic                       tick
);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [AW-1:0]              index_q, index_d;
  logic                       step_q, step_d;
  logic [CHAR_W-1:0]          mem_q [MSG_LEN];
  logic [CHAR_W-1:0]          mem_d [MSG_LEN];
  logic [DIGITS*CHAR_W-1:0]   chars_q, chars_d;
  logic                       tick_w;
  logic                       advance;

  // Modular add with one extra bit of headroom; both operands are below
  // MSG_LEN, so a single conditional subtract gives an exact wrap.
  function automatic logic [AW-1:0] mod_add(input logic [AW:0] a, input logic [AW:0] b);
    logic [AW:0] sum;
    sum = a + b;
    if (sum >= (AW+1)'(MSG_LEN)) sum = sum - (AW+1)'(MSG_LEN);
    return sum[AW-1:0];
  endfunction

  always_comb begin
    tick_w  = (cnt_q == CW'(TICK_MAX));
    cnt_d   = tick_w ? '0 : cnt_q + CW'(1);
    step_d  = step;
    // A tick and a step edge together still count as a single advance.
    advance = (tick_w && auto_en) || (step && !step_q);

    index_d = index_q;
    if (advance) begin
      if (dir) index_d = mod_add({1'b0, index_q}, (AW+1)'(MSG_LEN - 1));
      else     index_d = mod_add({1'b0, index_q}, (AW+1)'(1));
    end

    mem_d = mem_q;
    if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN))) mem_d[wr_addr] = wr_data;

    // Window is built from the pre-update index and memory, so it trails
    // index changes and writes by one cycle.
    chars_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      chars_d[(DIGITS-k)*CHAR_W-1 -: CHAR_W] = mem_q[mod_add({1'b0, index_q}, (AW+1)'(k))];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      index_q <= '0;
      step_q  <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) mem_q[i] <= CHAR_W'(i);
      for (int k = 0; k < DIGITS; k++) chars_q[(DIGITS-k)*CHAR_W-1 -: CHAR_W] <= CHAR_W'(k);
    end else begin
      cnt_q   <= cnt_d;
      index_q <= index_d;
      step_q  <= step_d;
      mem_q   <= mem_d;
      chars_q <= chars_d;
    end
  end

  assign chars = chars_q;
  assign index = index_q;
  assign tick  = tick_w;

endmodule

// File: tb/tb_message_scroller.sv
module tb_message_scroller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: MSG_LEN=16, DIGITS=4, CHAR_W=4, TICK_MAX=3
  logic        reset = 1'b1, auto_en = 1'b0, dir = 1'b0, step = 1'b0, wr_en = 1'b0;
  logic [3:0]  wr_addr = '0, wr_data = '0;
  logic [15:0] chars;
  logic [3:0]  index;
  logic        tick;

  message_scroller #(.MSG_LEN(16), .DIGITS(4), .CHAR_W(4), .TICK_MAX(3)) dut (
    .clk(clk), .reset(reset), .auto_en(auto_en), .dir(dir), .step(step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .chars(chars), .index(index), .tick(tick)
  );

  // Second instance with a non-power-of-2 message length
  logic        r12 = 1'b1, a12 = 1'b0, d12 = 1'b0, s12 = 1'b0, we12 = 1'b0;
  logic [3:0]  wa12 = '0, wd12 = '0;
  logic [15:0] chars12;
  logic [3:0]  index12;
  logic        tick12;

  message_scroller #(.MSG_LEN(12), .DIGITS(4), .CHAR_W(4), .TICK_MAX(3)) dut12 (
    .clk(clk), .reset(r12), .auto_en(a12), .dir(d12), .step(s12),
    .wr_en(we12), .wr_addr(wa12), .wr_data(wd12),
    .chars(chars12), .index(index12), .tick(tick12)
  );

  typedef struct {
    logic        rst, au, dr, st, we;
    logic [3:0]  addr, data;
    logic [3:0]  e_idx;
    logic [15:0] e_chars;
    logic        e_tick;
  } vec_t;

  typedef struct {
    logic [3:0]  e_idx;
    logic [15:0] e_chars;
    logic        e_tick;
    int          n;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, au, dr, st, we, input logic [3:0] addr, data,
                     input logic [3:0] e_idx, input logic [15:0] e_chars, input logic e_tick);
    vec_t v;
    v.rst = rst; v.au = au; v.dr = dr; v.st = st; v.we = we;
    v.addr = addr; v.data = data; v.e_idx = e_idx; v.e_chars = e_chars; v.e_tick = e_tick;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // rst au dr st we addr data | idx chars tick
    add(1,0,0,0,0,0,0,       0, 16'h0123, 0);
    add(1,0,0,0,0,0,0,       0, 16'h0123, 0);
    // auto scroll up
    add(0,1,0,0,0,0,0,       0, 16'h0123, 0);
    add(0,1,0,0,0,0,0,       0, 16'h0123, 0);
    add(0,1,0,0,0,0,0,       0, 16'h0123, 1);
    add(0,1,0,0,0,0,0,       1, 16'h0123, 0);
    add(0,1,0,0,0,0,0,       1, 16'h1234, 0);
    add(0,1,0,0,0,0,0,       1, 16'h1234, 0);
    add(0,1,0,0,0,0,0,       1, 16'h1234, 1);
    add(0,1,0,0,0,0,0,       2, 16'h1234, 0);
    add(0,1,0,0,0,0,0,       2, 16'h2345, 0);
    // reset beats a write; then auto scroll down
    add(1,1,1,0,1,0,4'hF,    0, 16'h0123, 0);
    add(0,1,1,0,0,0,0,       0, 16'h0123, 0);
    add(0,1,1,0,0,0,0,       0, 16'h0123, 0);
    add(0,1,1,0,0,0,0,       0, 16'h0123, 1);
    add(0,1,1,0,0,0,0,      15, 16'h0123, 0);
    add(0,1,1,0,0,0,0,      15, 16'hF012, 0);
    add(0,1,1,0,0,0,0,      15, 16'hF012, 0);
    add(0,1,1,0,0,0,0,      15, 16'hF012, 1);
    add(0,1,1,0,0,0,0,      14, 16'hF012, 0);
    add(0,1,1,0,0,0,0,      14, 16'hEF01, 0);
    // step held high for 10 cycles in manual mode
    add(1,0,0,0,0,0,0,       0, 16'h0123, 0);
    add(0,0,0,1,0,0,0,       1, 16'h0123, 0);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 0);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 1);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 0);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 0);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 0);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 1);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 0);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 0);
    add(0,0,0,1,0,0,0,       1, 16'h1234, 0);
    add(0,0,0,0,0,0,0,       1, 16'h1234, 1);
    // step edge coinciding with tick while auto: one advance only
    add(0,1,0,1,0,0,0,       2, 16'h1234, 0);
    add(0,0,0,0,0,0,0,       2, 16'h2345, 0);
    // write inside window, then write together with an advance
    add(1,0,0,0,0,0,0,       0, 16'h0123, 0);
    add(0,0,0,0,1,2,4'hA,    0, 16'h0123, 0);
    add(0,0,0,0,0,0,0,       0, 16'h01A3, 0);
    add(0,0,0,1,1,5,4'hC,    1, 16'h01A3, 1);
    add(0,0,0,0,0,0,0,       1, 16'h1A34, 0);
    add(0,0,0,1,0,0,0,       2, 16'h1A34, 0);
    add(0,0,0,0,0,0,0,       2, 16'hA34C, 0);
    // reset restores the default message
    add(1,0,0,0,0,0,0,       0, 16'h0123, 0);
    add(0,0,0,0,0,0,0,       0, 16'h0123, 0);
    add(0,0,0,1,0,0,0,       1, 16'h0123, 0);
    add(0,0,0,0,0,0,0,       1, 16'h1234, 1);
    add(0,0,0,1,0,0,0,       2, 16'h1234, 0);
    add(0,0,0,0,0,0,0,       2, 16'h2345, 0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      reset = tbl[i].rst; auto_en = tbl[i].au; dir = tbl[i].dr; step = tbl[i].st;
      wr_en = tbl[i].we; wr_addr = tbl[i].addr; wr_data = tbl[i].data;
      e.e_idx = tbl[i].e_idx; e.e_chars = tbl[i].e_chars; e.e_tick = tbl[i].e_tick; e.n = i;
      sb.push_back(e);
      cyc();
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check($sformatf("vec%0d_index", x.n), 32'(index), 32'(x.e_idx));
        check($sformatf("vec%0d_chars", x.n), 32'(chars), 32'(x.e_chars));
        check($sformatf("vec%0d_tick",  x.n), 32'(tick),  32'(x.e_tick));
      end
    end

    // Sequence: step to index 7 with writes, then a one-cycle reset
    reset = 1'b1; auto_en = 1'b0; dir = 1'b0; step = 1'b0; wr_en = 1'b0;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step = (i % 2 == 0);
      wr_en = (i < 4);
      wr_addr = 4'(i);
      wr_data = 4'(9 - i);
      cyc();
    end
    wr_en = 1'b0; step = 1'b0;
    check("seq7_index", 32'(index), 32'd7);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst7_index", 32'(index), 32'd0);
    check("rst7_chars", 32'(chars), 32'h0123);
    check("rst7_tick",  32'(tick),  32'd0);
    cyc();
    check("rst7_mem_chars", 32'(chars), 32'h0123);
    check("rst7_no_residual", 32'(index), 32'd0);

    // Sequence on MSG_LEN=12: out-of-range writes ignored, exact wrap
    r12 = 1'b1;
    cyc();
    check("m12_rst_index", 32'(index12), 32'd0);
    check("m12_rst_chars", 32'(chars12), 32'h0123);
    check("m12_rst_tick",  32'(tick12),  32'd0);
    r12 = 1'b0;
    we12 = 1'b1; wa12 = 4'd13; wd12 = 4'hF;
    cyc();
    wa12 = 4'd12; wd12 = 4'hE;
    cyc();
    we12 = 1'b0;
    cyc();
    check("m12_oob_chars", 32'(chars12), 32'h0123);
    check("m12_oob_index", 32'(index12), 32'd0);
    for (int i = 0; i < 11; i++) begin
      s12 = 1'b1; cyc();
      s12 = 1'b0; cyc();
    end
    check("m12_index11", 32'(index12), 32'd11);
    check("m12_chars11", 32'(chars12), 32'hB012);
    s12 = 1'b1; cyc();
    check("m12_wrap_up", 32'(index12), 32'd0);
    s12 = 1'b0; cyc();
    check("m12_chars0", 32'(chars12), 32'h0123);
    d12 = 1'b1; s12 = 1'b1; cyc();
    check("m12_wrap_down", 32'(index12), 32'd11);
    s12 = 1'b0; d12 = 1'b0; cyc();
    check("m12_chars_down", 32'(chars12), 32'hB012);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
